// File: rtl/draw_rect.sv
// rtl/draw_rect.sv - Rectangle overlay on a VGA pixel stream, 2-cycle latency, position handshake; macro DRAW_RECT_BORDER_EN adds a white 1-pixel border
module draw_rect #(
    parameter int          RECT_W     = 48,
    parameter int          RECT_H     = 64,
    parameter logic [11:0] RECT_COLOR = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        pos_valid,
    output logic        pos_ready,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out
);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t      state, state_next;
    logic [11:0] x_act, y_act, x_pend, y_pend;
    logic        vblnk_prev, vblnk_rise;
    logic        load_pend, load_direct, load_from_pend;

    assign vblnk_rise = vblnk_in & ~vblnk_prev;

    always_comb begin
        state_next     = state;
        pos_ready      = 1'b0;
        load_pend      = 1'b0;
        load_direct    = 1'b0;
        load_from_pend = 1'b0;
        case (state)
            IDLE: begin
                pos_ready = ~rst;
                if (pos_valid) begin
                    if (vblnk_rise) begin
                        load_direct = 1'b1;
                    end else begin
                        load_pend  = 1'b1;
                        state_next = PENDING;
                    end
                end
            end
            PENDING: begin
                if (vblnk_rise) begin
                    load_from_pend = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x_act      <= '0;
            y_act      <= '0;
            x_pend     <= '0;
            y_pend     <= '0;
            vblnk_prev <= 1'b0;
        end else begin
            state      <= state_next;
            vblnk_prev <= vblnk_in;
            if (load_pend) begin
                x_pend <= xpos;
                y_pend <= ypos;
            end
            if (load_direct) begin
                x_act <= xpos;
                y_act <= ypos;
            end else if (load_from_pend) begin
                x_act <= x_pend;
                y_act <= y_pend;
            end
        end
    end

    // 13-bit bounds: a rectangle hanging past the screen edge is clipped, never wrapped
    logic [12:0] h_ext, v_ext, x_lo, y_lo, x_hi, y_hi;
    logic        hit;
    logic [11:0] rect_px;

    assign h_ext = {2'b00, hcount_in};
    assign v_ext = {2'b00, vcount_in};
    assign x_lo  = {1'b0, x_act};
    assign y_lo  = {1'b0, y_act};
    assign x_hi  = x_lo + 13'(RECT_W);
    assign y_hi  = y_lo + 13'(RECT_H);
    assign hit   = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi);

`ifdef DRAW_RECT_BORDER_EN
    assign rect_px = (h_ext == x_lo || h_ext == x_hi - 13'd1 ||
                      v_ext == y_lo || v_ext == y_hi - 13'd1) ? 12'hFFF : RECT_COLOR;
`else
    assign rect_px = RECT_COLOR;
`endif

    logic [10:0] vcount_d, hcount_d;
    logic        vsync_d, vblnk_d, hsync_d, hblnk_d, hit_d;
    logic [11:0] rgb_d, rect_px_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            vcount_d   <= '0;
            hcount_d   <= '0;
            vsync_d    <= 1'b0;
            vblnk_d    <= 1'b0;
            hsync_d    <= 1'b0;
            hblnk_d    <= 1'b0;
            hit_d      <= 1'b0;
            rgb_d      <= '0;
            rect_px_d  <= '0;
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            vcount_d   <= vcount_in;
            hcount_d   <= hcount_in;
            vsync_d    <= vsync_in;
            vblnk_d    <= vblnk_in;
            hsync_d    <= hsync_in;
            hblnk_d    <= hblnk_in;
            hit_d      <= hit;
            rgb_d      <= rgb_in;
            rect_px_d  <= rect_px;
            vcount_out <= vcount_d;
            hcount_out <= hcount_d;
            vsync_out  <= vsync_d;
            vblnk_out  <= vblnk_d;
            hsync_out  <= hsync_d;
            hblnk_out  <= hblnk_d;
            if (hblnk_d || vblnk_d)
                rgb_out <= 12'h000;
            else
                rgb_out <= hit_d ? rect_px_d : rgb_d;
        end
    end

endmodule

// File: doc/draw_rect.md
DRAW_RECT -- requirements
Module: draw_rect

Interface
REQ-001 Parameter RECT_W, default 48, rectangle width in pixels (1..800).
REQ-002 Parameter RECT_H, default 64, rectangle height in pixels (1..600).
REQ-003 Parameter RECT_COLOR, default 12'hF00, 12-bit RGB444 rectangle fill colour.
REQ-004 clk  input  1  pixel clock, 40 MHz; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 vcount_in, hcount_in  input  11 each  pixel counters from the vga_timing stage.
REQ-007 vsync_in, vblnk_in, hsync_in, hblnk_in  input  1 each  sync and blanking from the vga_timing stage.
REQ-008 rgb_in  input  12  background pixel colour aligned with the *_in timing signals.
REQ-009 pos_valid  input  1  new rectangle position offered.
REQ-010 pos_ready  output  1  block can accept a new position.
REQ-011 xpos, ypos  input  12 each  top-left corner of the offered position, sampled on handshake.
REQ-012 vcount_out, hcount_out  output  11 each  delayed counters.
REQ-013 vsync_out, vblnk_out, hsync_out, hblnk_out  output  1 each  delayed sync and blanking.
REQ-014 rgb_out  output  12  composited pixel colour.

Function
REQ-015 Every *_out timing signal SHALL equal its *_in counterpart delayed by exactly 2 clk cycles.
REQ-016 rgb_out SHALL be aligned with the *_out timing signals (2-cycle latency from rgb_in and the counters).
REQ-017 rgb_out SHALL be 12'h000 when the delayed hblnk or vblnk is 1.
REQ-018 Otherwise rgb_out SHALL be RECT_COLOR when x_act <= hcount < x_act+RECT_W and y_act <= vcount < y_act+RECT_H, else the delayed rgb_in.
REQ-019 Sums x_act+RECT_W and y_act+RECT_H SHALL be computed at 13 bits with no wrap-around, so rectangles crossing the right or bottom edge are clipped.
REQ-020 Handshake FSM states: IDLE (pos_ready=1) and PENDING (pos_ready=0).
REQ-021 IDLE with pos_valid=1 SHALL capture xpos/ypos into a pending register and go to PENDING on the next edge.
REQ-022 A vblnk rising edge is detected when vblnk_in=1 and the registered previous vblnk_in=0.
REQ-023 PENDING at a vblnk rising edge SHALL copy pending into x_act/y_act and return to IDLE; pos_ready SHALL be 1 in the following cycle.
REQ-024 A handshake coinciding with a vblnk rising edge in IDLE SHALL load xpos/ypos directly into x_act/y_act, and the FSM SHALL stay in IDLE.
REQ-025 x_act/y_act SHALL change only on vblnk rising edges (no tearing within a visible frame).
REQ-026 pos_valid in PENDING SHALL be ignored; the pending value SHALL NOT be overwritten.

Reset
REQ-027 While rst=1, all *_out signals and rgb_out SHALL be 0 and pos_ready SHALL be 0.
REQ-028 Reset SHALL set x_act=y_act=0, clear the pending register and previous-vblnk flag, and force the FSM to IDLE.
REQ-029 pos_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 Reset in PENDING SHALL discard the pending position.

Configuration
REQ-031 Macro DRAW_RECT_BORDER_EN: when defined, pixels on the outermost 1-pixel ring of the rectangle SHALL be 12'hFFF and the interior RECT_COLOR.
REQ-032 When DRAW_RECT_BORDER_EN is undefined, the whole rectangle SHALL be RECT_COLOR.
REQ-033 Latency and handshake behaviour SHALL be identical in both builds.

Verification
REQ-034 Scenario: drive the block from vga_timing with rgb_in=12'h8_8_8. Required: every *_out equals *_in delayed 2 cycles for a full frame, and rgb_out=0 whenever the delayed blanking is 1.
REQ-035 Scenario: offer pos 100,200 mid-frame. Required: pos_ready drops next cycle; the current frame keeps the old position; from the next frame, rgb_out=12'hF00 at hcount 100..147, vcount 200..263 and 12'h888 at hcount 148.
REQ-036 Scenario: offer pos 780,580. Required: the red area covers hcount 780..799 and vcount 580..599 only; there is no wrap to column 0 or row 0.
REQ-037 Scenario: pos_valid held through PENDING with a second value 10,10. Required: 10,10 is ignored, and the first value is applied at the vblnk rise.
REQ-038 Scenario: assert rst for 2 cycles while PENDING. Required: all outputs are 0 during reset, pos_ready=1 one cycle after release, and the rectangle is drawn at 0,0 next frame.
REQ-039 Scenario: build with DRAW_RECT_BORDER_EN and pos 100,200. Required: pixel (100,200)=12'hFFF, (147,263)=12'hFFF and (101,201)=12'hF00.
